// File: rtl/traffic_lights_multi_pkg.sv
// Shared types for the multi-approach traffic light controller.
package traffic_lights_multi_pkg;

    // Command codes on cmd_type_i
    typedef enum logic [2:0] {
        CmdOn        = 3'd0,
        CmdOff       = 3'd1,
        CmdUnstd     = 3'd2,
        CmdSetGreen  = 3'd3,
        CmdSetRed    = 3'd4,
        CmdSetYellow = 3'd5,
        CmdSkip      = 3'd6,
        CmdNop       = 3'd7
    } cmd_t;

    // Controller states; the active approach is held separately
    typedef enum logic [2:0] {
        StOff,
        StUnstd,
        StAllRed,
        StRy,
        StGreen,
        StGblink,
        StYellow
    } state_t;

    // Blink phase values
    localparam logic BlinkOn  = 1'b1;
    localparam logic BlinkOff = 1'b0;

endpackage

// File: rtl/tl_unit_timer.sv
// Unit timer: a prescaler divides clk_i into time units, a down-counter counts
// the units of the current state, and a half-period counter paces blinking.
// done_o is high in the last clock of the loaded duration. Loading 0 units
// keeps the prescaler and blink pacing running without ever raising done_o.
module tl_unit_timer #(
    parameter int unsigned DATA_W           = 16,
    parameter int unsigned TICKS_PER_UNIT   = 2,
    parameter int unsigned BLINK_HALF_UNITS = 1
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              load_i,
    input  logic [DATA_W-1:0] units_i,
    output logic              done_o,
    output logic              half_tick_o
);

    localparam int unsigned PreW  = (TICKS_PER_UNIT > 1) ? $clog2(TICKS_PER_UNIT) : 1;
    localparam int unsigned HalfW = (BLINK_HALF_UNITS > 1) ? $clog2(BLINK_HALF_UNITS) : 1;
    localparam logic [PreW-1:0]  PreMax  = PreW'(TICKS_PER_UNIT - 1);
    localparam logic [HalfW-1:0] HalfMax = HalfW'(BLINK_HALF_UNITS - 1);

    logic [PreW-1:0]   pre_q, pre_d;
    logic [DATA_W-1:0] cnt_q, cnt_d;
    logic [HalfW-1:0]  half_q, half_d;
    logic              unit_end;

    assign unit_end    = (pre_q == '0);
    assign done_o      = unit_end && (cnt_q == DATA_W'(1));
    assign half_tick_o = unit_end && (half_q == HalfMax);

    // Next-state for prescaler, unit counter and half-period counter
    always_comb begin
        pre_d  = pre_q;
        cnt_d  = cnt_q;
        half_d = half_q;
        if (load_i) begin
            pre_d  = PreMax;
            cnt_d  = units_i;
            half_d = '0;
        end else if (unit_end) begin
            pre_d  = PreMax;
            half_d = half_tick_o ? '0 : half_q + HalfW'(1);
            if (cnt_q != '0) begin
                cnt_d = cnt_q - DATA_W'(1);
            end
        end else begin
            pre_d = pre_q - PreW'(1);
        end
    end

    // Timer state registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pre_q  <= '0;
            cnt_q  <= '0;
            half_q <= '0;
        end else begin
            pre_q  <= pre_d;
            cnt_q  <= cnt_d;
            half_q <= half_d;
        end
    end

endmodule

// File: rtl/traffic_lights_multi.sv
// Round-robin traffic light controller for NUM_CH approaches of one
// intersection, with an all-red clearance before every grant.
// Optional feature macro: TRAFFIC_LIGHTS_MULTI_SKIP_EN enables the SKIP
// command (truncate GREEN and go straight to GBLINK).
module traffic_lights_multi
    import traffic_lights_multi_pkg::*;
#(
    parameter int unsigned NUM_CH           = 2,
    parameter int unsigned CH_W             = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    parameter int unsigned DATA_W           = 16,
    parameter int unsigned TICKS_PER_UNIT   = 2,
    parameter int unsigned RED_YELLOW_UNITS = 3,
    parameter int unsigned BLINK_HALF_UNITS = 1,
    parameter int unsigned GREEN_BLINKS     = 3,
    parameter int unsigned DEF_GREEN        = 10,
    parameter int unsigned DEF_YELLOW       = 5,
    parameter int unsigned DEF_RED          = 4
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [2:0]        cmd_type_i,
    input  logic              cmd_valid_i,
    input  logic [DATA_W-1:0] cmd_data_i,
    input  logic [CH_W-1:0]   cmd_ch_i,
    output logic [NUM_CH-1:0] red_o,
    output logic [NUM_CH-1:0] yellow_o,
    output logic [NUM_CH-1:0] green_o
);

    localparam logic [CH_W-1:0] LastCh = CH_W'(NUM_CH - 1);

    state_t            state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic              blink_q, blink_d;
    logic [DATA_W-1:0] green_t_q  [NUM_CH];
    logic [DATA_W-1:0] green_t_d  [NUM_CH];
    logic [DATA_W-1:0] yellow_t_q [NUM_CH];
    logic [DATA_W-1:0] yellow_t_d [NUM_CH];
    logic [DATA_W-1:0] red_t_q, red_t_d;

    logic              load;
    logic [DATA_W-1:0] load_units;
    logic              t_done;
    logic              half_tick;
    logic              cmd_taken;
    logic              set_ok;
    logic              ch_ok;

    tl_unit_timer #(
        .DATA_W           (DATA_W),
        .TICKS_PER_UNIT   (TICKS_PER_UNIT),
        .BLINK_HALF_UNITS (BLINK_HALF_UNITS)
    ) u_timer (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .load_i      (load),
        .units_i     (load_units),
        .done_o      (t_done),
        .half_tick_o (half_tick)
    );

    // Command decode and sequence advance; a state-changing command beats timer expiry
    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        blink_d    = blink_q;
        green_t_d  = green_t_q;
        yellow_t_d = yellow_t_q;
        red_t_d    = red_t_q;
        load       = 1'b0;
        cmd_taken  = 1'b0;
        set_ok     = (state_q == StUnstd) && (cmd_data_i != '0);
        ch_ok      = (32'(cmd_ch_i) < NUM_CH);

        if ((state_q == StUnstd || state_q == StGblink) && half_tick) begin
            blink_d = ~blink_q;
        end

        if (cmd_valid_i) begin
            case (cmd_t'(cmd_type_i))
                CmdOn: begin
                    if (state_q == StOff || state_q == StUnstd) begin
                        state_d   = StAllRed;
                        ch_d      = '0;
                        cmd_taken = 1'b1;
                    end
                end
                CmdOff: begin
                    state_d   = StOff;
                    cmd_taken = 1'b1;
                end
                CmdUnstd: begin
                    state_d   = StUnstd;
                    blink_d   = BlinkOn;
                    cmd_taken = 1'b1;
                end
                CmdSetGreen: begin
                    if (set_ok && ch_ok) green_t_d[cmd_ch_i] = cmd_data_i;
                end
                CmdSetRed: begin
                    if (set_ok) red_t_d = cmd_data_i;
                end
                CmdSetYellow: begin
                    if (set_ok && ch_ok) yellow_t_d[cmd_ch_i] = cmd_data_i;
                end
`ifdef TRAFFIC_LIGHTS_MULTI_SKIP_EN
                CmdSkip: begin
                    if (state_q == StGreen) begin
                        state_d   = StGblink;
                        blink_d   = BlinkOff;
                        cmd_taken = 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end

        if (cmd_taken) begin
            load = 1'b1;
        end else if (t_done) begin
            case (state_q)
                StAllRed: begin
                    state_d = StRy;
                    load    = 1'b1;
                end
                StRy: begin
                    state_d = StGreen;
                    load    = 1'b1;
                end
                StGreen: begin
                    state_d = StGblink;
                    blink_d = BlinkOff;
                    load    = 1'b1;
                end
                StGblink: begin
                    state_d = StYellow;
                    load    = 1'b1;
                end
                StYellow: begin
                    state_d = StAllRed;
                    ch_d    = (ch_q == LastCh) ? '0 : ch_q + CH_W'(1);
                    load    = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Duration of the state being entered, from the registered timing tables
    always_comb begin
        load_units = '0;
        case (state_d)
            StAllRed: load_units = red_t_q;
            StRy:     load_units = DATA_W'(RED_YELLOW_UNITS);
            StGreen:  load_units = green_t_q[ch_d];
            StGblink: load_units = DATA_W'(2 * GREEN_BLINKS * BLINK_HALF_UNITS);
            StYellow: load_units = yellow_t_q[ch_d];
            default:  load_units = '0;
        endcase
    end

    // State, channel, blink phase and timing-table registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= StOff;
            ch_q    <= '0;
            blink_q <= BlinkOff;
            red_t_q <= DATA_W'(DEF_RED);
            for (int k = 0; k < NUM_CH; k++) begin
                green_t_q[k]  <= DATA_W'(DEF_GREEN);
                yellow_t_q[k] <= DATA_W'(DEF_YELLOW);
            end
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            blink_q    <= blink_d;
            red_t_q    <= red_t_d;
            green_t_q  <= green_t_d;
            yellow_t_q <= yellow_t_d;
        end
    end

    // Moore lamp decode from registered state only
    always_comb begin
        red_o    = '0;
        yellow_o = '0;
        green_o  = '0;
        case (state_q)
            StUnstd:  yellow_o = {NUM_CH{blink_q}};
            StAllRed: red_o = '1;
            StRy: begin
                red_o          = '1;
                yellow_o[ch_q] = 1'b1;
            end
            StGreen: begin
                red_o         = '1;
                red_o[ch_q]   = 1'b0;
                green_o[ch_q] = 1'b1;
            end
            StGblink: begin
                red_o         = '1;
                red_o[ch_q]   = 1'b0;
                green_o[ch_q] = blink_q;
            end
            StYellow: begin
                red_o          = '1;
                red_o[ch_q]    = 1'b0;
                yellow_o[ch_q] = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_traffic_lights_multi.sv
// Bench for traffic_lights_multi (NUM_CH=2, TICKS_PER_UNIT=2). Expected lamp
// vectors {red, yellow, green} are queued per cycle and compared on negedge.
module tb_traffic_lights_multi;
    import traffic_lights_multi_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic [2:0]  cmd_type_i;
    logic        cmd_valid_i;
    logic [15:0] cmd_data_i;
    logic        cmd_ch_i;
    logic [1:0]  red_o, yellow_o, green_o;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        string      tag;
        logic [5:0] lamps;
    } exp_t;

    exp_t sb[$];
    exp_t popped;

    // {red[1:0], yellow[1:0], green[1:0]}
    localparam logic [5:0] LOff   = 6'b00_00_00;
    localparam logic [5:0] AllRed = 6'b11_00_00;
    localparam logic [5:0] Ry0    = 6'b11_01_00;
    localparam logic [5:0] G0     = 6'b10_00_01;
    localparam logic [5:0] B0Off  = 6'b10_00_00;
    localparam logic [5:0] Y0     = 6'b10_01_00;
    localparam logic [5:0] Ry1    = 6'b11_10_00;
    localparam logic [5:0] G1     = 6'b01_00_10;
    localparam logic [5:0] B1Off  = 6'b01_00_00;
    localparam logic [5:0] Y1     = 6'b01_10_00;
    localparam logic [5:0] UOn    = 6'b00_11_00;

    traffic_lights_multi #(
        .NUM_CH         (2),
        .TICKS_PER_UNIT (2)
    ) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .cmd_type_i  (cmd_type_i),
        .cmd_valid_i (cmd_valid_i),
        .cmd_data_i  (cmd_data_i),
        .cmd_ch_i    (cmd_ch_i),
        .red_o       (red_o),
        .yellow_o    (yellow_o),
        .green_o     (green_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [5:0] got, input logic [5:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got r/y/g=%b expected %b at %0t", tag, got, exp, $time);
    endtask

    // Scoreboard drain: one expected vector per cycle
    always @(negedge clk_i) begin
        if (sb.size() > 0) begin
            popped = sb.pop_front();
            check_eq(popped.tag, {red_o, yellow_o, green_o}, popped.lamps);
        end
    end

    task automatic idle(input string tag, input logic [5:0] lamps, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.tag   = tag;
            e.lamps = lamps;
            sb.push_back(e);
            @(posedge clk_i);
            #1;
        end
    endtask

    // One command cycle; lamps is what the current state shows during it
    task automatic send_cmd(input logic [2:0] t, input logic [15:0] d, input logic c,
                            input string tag, input logic [5:0] lamps);
        exp_t e;
        cmd_type_i  = t;
        cmd_data_i  = d;
        cmd_ch_i    = c;
        cmd_valid_i = 1'b1;
        e.tag       = tag;
        e.lamps     = lamps;
        sb.push_back(e);
        @(posedge clk_i);
        #1;
        cmd_valid_i = 1'b0;
        cmd_type_i  = CmdNop;
    endtask

    task automatic blink(input string tag, input logic [5:0] off_l, input logic [5:0] on_l);
        for (int i = 0; i < 3; i++) begin
            idle(tag, off_l, 2);
            idle(tag, on_l, 2);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n_i     = 1'b0;
        cmd_valid_i = 1'b0;
        cmd_type_i  = CmdNop;
        cmd_data_i  = '0;
        cmd_ch_i    = 1'b0;
        #3;
        check_eq("reset", {red_o, yellow_o, green_o}, LOff);
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;
        idle("off_idle", LOff, 2);

        // Full default cycle for ch0, then into ch1
        send_cmd(CmdOn, 16'd0, 1'b0, "on_from_off", LOff);
        idle("allred", AllRed, 8);
        idle("ry0", Ry0, 6);
        idle("green0", G0, 20);
        blink("gblink0", B0Off, G0);
        idle("yellow0", Y0, 10);
        idle("allred", AllRed, 8);
        idle("ry1", Ry1, 6);
        idle("green1", G1, 19);
        // Last green cycle coincides with expiry; the command wins
        send_cmd(CmdUnstd, 16'd0, 1'b0, "unstd_at_expiry", G1);

        // Per-channel green, zero-data yellow ignored
        idle("unstd_on", UOn, 2);
        idle("unstd_off", LOff, 2);
        send_cmd(CmdSetGreen, 16'd4, 1'b1, "set_green1", UOn);
        send_cmd(CmdSetYellow, 16'd0, 1'b0, "set_yellow0_zero", UOn);
        send_cmd(CmdOn, 16'd0, 1'b0, "on_from_unstd", LOff);
        idle("allred", AllRed, 8);
        idle("ry0", Ry0, 6);
        idle("green0", G0, 5);
        send_cmd(CmdSetGreen, 16'd2, 1'b0, "set_in_green", G0);
        idle("green0", G0, 14);
        blink("gblink0", B0Off, G0);
        idle("yellow0_default", Y0, 10);
        idle("allred", AllRed, 8);
        idle("ry1", Ry1, 6);
        idle("green1_short", G1, 8);
        blink("gblink1", B1Off, G1);
        idle("yellow1", Y1, 10);
        idle("allred", AllRed, 8);
        idle("ry0", Ry0, 6);
        idle("green0_kept", G0, 20);

        // OFF during GBLINK, then UNSTD blinking
        idle("gblink0", B0Off, 2);
        send_cmd(CmdOff, 16'd0, 1'b0, "off_in_gblink", G0);
        idle("off", LOff, 3);
        send_cmd(CmdUnstd, 16'd0, 1'b0, "unstd_cmd", LOff);
        idle("unstd_on", UOn, 2);
        idle("unstd_off", LOff, 2);
        send_cmd(CmdNop, 16'd0, 1'b0, "cmd7_ignored", UOn);
        idle("unstd_on", UOn, 1);
        idle("unstd_off", LOff, 2);
        send_cmd(CmdOn, 16'd0, 1'b0, "on_again", UOn);

        // Asynchronous reset mid-GREEN
        idle("allred", AllRed, 8);
        idle("ry0", Ry0, 6);
        idle("green0", G0, 5);
        #2;
        rst_n_i = 1'b0;
        #1;
        check_eq("async_reset", {red_o, yellow_o, green_o}, LOff);
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;
        idle("off_after_rst", LOff, 1);
        send_cmd(CmdOn, 16'd0, 1'b0, "on_after_rst", LOff);
        idle("allred", AllRed, 8);
        idle("ry0", Ry0, 6);

        // SKIP: truncates green only when the feature is built in
`ifdef TRAFFIC_LIGHTS_MULTI_SKIP_EN
        idle("green0", G0, 3);
        send_cmd(CmdSkip, 16'd0, 1'b0, "skip", G0);
`else
        idle("green0", G0, 3);
        send_cmd(CmdSkip, 16'd0, 1'b0, "skip_ignored", G0);
        idle("green0_full", G0, 16);
`endif
        blink("gblink0", B0Off, G0);
        idle("yellow0", Y0, 10);
        idle("allred", AllRed, 8);
        idle("ry1", Ry1, 6);
        idle("green1_default", G1, 20);
        idle("gblink1_start", B1Off, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
